dyser_input_port: RTL and testbench

- Transmit end of the fabric's credit-based link protocol. Fabric FUs and switches receive on this link.
- Accepts host operands through a valid/ready handshake and buffers them in a small FIFO.
- Injects each operand into an edge switch as a {data, valid} path word, one token per downstream credit.
- Tracks downstream buffer space with a credit counter replenished by credit pulses returned from the fabric.

---
 rtl/dyser_input_port_pkg.sv | 12 +
 rtl/dyser_input_port_fifo.sv | 41 ++++
 rtl/dyser_input_port.sv | 59 +++++
 tb/tb_dyser_input_port.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/dyser_input_port_pkg.sv
// dyser_input_port_pkg: shared path-word layout, credit defaults and counter width helper
package dyser_input_port_pkg;
  localparam int VALID_BIT = 0;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CREDITS = 2;
  function automatic int path_w(input int dw);
    return dw + 1;
  endfunction
  function automatic int cnt_w(input int c);
    return $clog2(c + 1);
  endfunction
endpackage

// File: rtl/dyser_input_port_fifo.sv
// iport_fifo: synchronous FIFO (push/pop/head/count/full/empty), async active-low reset rst
module iport_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din;
  assign head = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/dyser_input_port.sv
// dyser_input_port: credit-based transmit port; clk, rst (async active-low), enable, in_* host handshake, d_out path word, credit_in/credit_cnt, cred_err (IPORT_CREDIT_CHECK_EN)
module dyser_input_port
  import dyser_input_port_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDITS = DEF_CREDITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [path_w(DATA_W)-1:0]    d_out,
  input  logic                         credit_in,
  output logic [cnt_w(CREDITS)-1:0]    credit_cnt,
  output logic                         cred_err
);
  localparam int CW = cnt_w(CREDITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] fifo_head;
  logic [AW:0] fifo_count;
  logic fifo_full, fifo_empty, send;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [path_w(DATA_W)-1:0] d_out_q, d_out_d;
  iport_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk(clk), .rst(rst), .push(in_valid & ~fifo_full), .pop(send), .din(in_data),
    .head(fifo_head), .count(fifo_count), .full(fifo_full), .empty(fifo_empty)
  );
  assign in_ready = fifo_count != (AW+1)'(FIFO_DEPTH);
  assign send = ~fifo_empty & (cnt_q != '0) & enable;
  always_comb begin
    d_out_d = send ? {fifo_head, 1'b1} : '0;
    cnt_d = (send & ~credit_in) ? cnt_q - CW'(1) :
            (credit_in & ~send & cnt_q != CW'(CREDITS)) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= CW'(CREDITS);
      d_out_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      d_out_q <= d_out_d;
    end
`ifdef IPORT_CREDIT_CHECK_EN
  logic err_q, err_d;
  // a return with no outstanding token (counter already full, nothing sent) is a protocol error
  assign err_d = err_q | (credit_in & ~send & cnt_q == CW'(CREDITS));
  always_ff @(posedge clk or negedge rst)
    if (!rst) err_q <= 1'b0;
    else err_q <= err_d;
  assign cred_err = err_q;
`else
  assign cred_err = 1'b0;
`endif
  assign d_out = d_out_q;
  assign credit_cnt = cnt_q;
endmodule

// File: tb/tb_dyser_input_port.sv
// tb_dyser_input_port: scoreboard bench for dyser_input_port
module tb_dyser_input_port;
  logic clk = 0, rst = 0, enable = 0, in_valid = 0, credit_in = 0;
  logic [31:0] in_data = 0;
  logic in_ready, cred_err;
  logic [32:0] d_out;
  logic [1:0] credit_cnt;
  int n_cmp = 0, n_bad = 0, n_valid = 0;
  logic [31:0] sb [$];
  logic exp_err;
  dyser_input_port dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .d_out(d_out), .credit_in(credit_in), .credit_cnt(credit_cnt),
    .cred_err(cred_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (d_out[0]) begin
      n_valid++;
      if (sb.size() == 0) chk("unexpected_token", {31'b0, d_out}, 64'h0);
      else chk("token", {32'b0, d_out[32:1]}, {32'b0, sb.pop_front()});
    end else chk("idle_zero", {31'b0, d_out}, 64'h0);
  end
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic push(input logic [31:0] d);
    logic acc;
    in_valid = 1; in_data = d;
    for (int i = 0; i < 50; i++) begin
      acc = in_ready;
      cyc(1);
      if (acc) begin
        sb.push_back(d);
        in_valid = 0;
        return;
      end
    end
    in_valid = 0;
    chk("push_timeout", 64'h0, 64'h1);
  endtask
  task automatic credit_pulse();
    credit_in = 1; cyc(1); credit_in = 0;
  endtask
  initial begin
`ifdef IPORT_CREDIT_CHECK_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_dout", {31'b0, d_out}, 64'h0);
    chk("rst_cnt", {62'b0, credit_cnt}, 64'd2);
    chk("rst_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_err", {63'b0, cred_err}, 64'd0);
    @(negedge clk); rst = 1; enable = 1;
    @(posedge clk); #1;
    // single token latency
    push(32'hA5);
    @(negedge clk);
    chk("lat_not_yet", {31'b0, d_out}, 64'h0);
    @(negedge clk);
    chk("lat_token", {31'b0, d_out}, {31'b0, 32'hA5, 1'b1});
    #1 chk("cnt_after_one", {62'b0, credit_cnt}, 64'd1);
    @(posedge clk); #1;
    credit_pulse();
    chk("cnt_restored", {62'b0, credit_cnt}, 64'd2);
    // credit exhaustion
    push(32'h1); push(32'h2); push(32'h3);
    cyc(3);
    chk("exhaust_cnt", {62'b0, credit_cnt}, 64'd0);
    chk("exhaust_held", sb.size(), 64'd1);
    credit_pulse();
    @(negedge clk);
    chk("credit_wait", {31'b0, d_out}, 64'h0);
    @(negedge clk);
    chk("credit_send", {31'b0, d_out}, {31'b0, 32'h3, 1'b1});
    @(posedge clk); #1;
    chk("credit_cnt0", {62'b0, credit_cnt}, 64'd0);
    // fifo full with enable low
    enable = 0;
    credit_pulse(); credit_pulse();
    chk("refill_cnt", {62'b0, credit_cnt}, 64'd2);
    for (int i = 0; i < 4; i++) push(32'h10 + i);
    chk("full_ready", {63'b0, in_ready}, 64'd0);
    in_valid = 1; in_data = 32'h14;
    cyc(3);
    chk("full_refuse", {63'b0, in_ready}, 64'd0);
    in_valid = 0; enable = 1;
    cyc(1);
    chk("ready_after_pop", {63'b0, in_ready}, 64'd1);
    cyc(3);
    chk("drain_cnt", {62'b0, credit_cnt}, 64'd0);
    chk("drain_held", sb.size(), 64'd2);
    repeat (4) credit_pulse();
    cyc(3);
    chk("drain_done", sb.size(), 64'd0);
    chk("drain_cnt2", {62'b0, credit_cnt}, 64'd2);
    // simultaneous send and credit
    begin
      int v0;
      v0 = n_valid;
      for (int i = 0; i < 9; i++) begin
        in_valid = i < 8; in_data = 32'h20 + i; credit_in = i > 0;
        cyc(1);
        if (i < 8) sb.push_back(32'h20 + i);
        chk("stream_cnt", {62'b0, credit_cnt}, 64'd2);
      end
      in_valid = 0; credit_in = 0;
      @(negedge clk); #1;
      chk("stream_rate", n_valid - v0, 64'd8);
    end
    cyc(2);
    chk("pre_ovf_err", {63'b0, cred_err}, 64'd0);
    // overflow
    credit_pulse();
    chk("ovf_cnt", {62'b0, credit_cnt}, 64'd2);
    chk("ovf_err", {63'b0, cred_err}, {63'b0, exp_err});
    cyc(3);
    chk("ovf_sticky", {63'b0, cred_err}, {63'b0, exp_err});
    // reset mid-stream
    for (int i = 0; i < 5; i++) push(32'h30 + i);
    cyc(2);
    chk("mid_cnt", {62'b0, credit_cnt}, 64'd0);
    chk("mid_held", sb.size(), 64'd3);
    #2 rst = 0; sb.delete();
    #1;
    chk("mid_rst_dout", {31'b0, d_out}, 64'h0);
    chk("mid_rst_cnt", {62'b0, credit_cnt}, 64'd2);
    chk("mid_rst_ready", {63'b0, in_ready}, 64'd1);
    chk("mid_rst_err", {63'b0, cred_err}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    cyc(5);
    chk("post_rst_cnt", {62'b0, credit_cnt}, 64'd2);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1);
    chk("sb_empty", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
